cla_pipe_adder: RTL
===================

# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor, the successor to the fixed 16-bit four-group CLA. Operand width is split into SEG_WIDTH-bit lookahead segments; each pipeline stage resolves one segment and forwards its carry to the next stage, so width scales without lengthening the critical path. A valid/ready handshake on both sides lets it sit in an ALU datapath with back-pressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 8, bits resolved per stage; must be a multiple of 4. Each segment is built from 4-bit lookahead groups.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_a, in_b  in  WIDTH  operands.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0 = A+B+cin, 1 = A-B, computed as A+~B+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the beat.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of the MSB. For subtract this is the no-borrow flag.
- out_p, out_g  out  1  whole-word group propagate and generate.
- out_zero, out_ovf  out  1  present only with CLA_FLAGS_EN.

## Operation
- NSEG = WIDTH/SEG_WIDTH stages. Stage k (0..NSEG-1) adds segment k of A and B' (B' = in_sub ? ~B : B) using the carry from stage k-1. Stage 0 uses in_sub ? 1 : in_cin.
- Segments not yet resolved travel forward in skew registers. Segments already resolved travel forward as sum bits.
- Group P/G accumulate per stage:
  - P_acc = P_acc & P_k
  - G_acc = G_k | (P_k & G_acc)
- out_cout is the carry out of the final stage, i.e. G_acc | (P_acc & c0).
- Pipeline stalls as a whole:
  - advance = out_ready | ~out_valid.
  - in_ready = advance.
  - A beat transfers when in_valid & in_ready.
- On advance, each stage valid bit takes the previous stage's valid bit. Stage 0 takes in_valid.
- Bubbles are permitted. The pipeline accepts one beat per cycle at full throughput.
- Without advance, all stage registers hold their values. out_* stay stable while out_valid=1 & out_ready=0.
- Results leave in acceptance order; there is no reordering.
- Width rule: out_sum is (A + B' + c0) mod 2^WIDTH.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+NSEG-1 (NSEG cycles, counting the acceptance cycle), assuming no stall.
- Reset values: all stage valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_p=0, out_g=0, out_zero=0, out_ovf=0.
- in_ready=1 during rst=0 while the pipeline is empty.
- Reset mid-operation: all in-flight beats are discarded, nothing is emitted, and the pipeline is empty on the cycle after rst deasserts.
- Simultaneous accept and emit with out_ready=1: both occur in the same cycle and the pipeline stays full.
- Full pipe with out_ready=0: in_ready=0 and no beat is lost.

## Configuration
- CLA_FLAGS_EN defined:
  - out_zero = (out_sum == 0).
  - out_ovf = signed overflow = carry into MSB XOR carry out of MSB.
  - Both are registered with the final stage and have the same latency as out_sum.
- Undefined: out_zero and out_ovf ports and their logic are absent. All other behaviour is identical.

## Structure
- Package cla_pkg holds:
  - the CLA_GROUP constant (4);
  - localparam helpers for NSEG;
  - a stage-register struct {valid, a, b, sum, carry, p_acc, g_acc}.
- Sub-module cla_segment: combinational SEG_WIDTH-bit lookahead adder (inputs a, b, cin; outputs sum, cout, p, g), built from 4-bit groups with a second-level lookahead over the group P/G. One instance per stage.

## Test plan
- WIDTH=32, SEG_WIDTH=8: 0x0000_FFFF + 0x0000_0001, cin=0 → out_sum=0x0001_0000, out_cout=0; out_valid rises exactly 4 cycles after acceptance.
- 0xFFFF_FFFF + 0x0000_0000, cin=1 → out_sum=0, out_cout=1, out_p=1, out_g=0; with flags, out_zero=1.
- in_sub=1, 5-7 → out_sum=0xFFFF_FFFE, out_cout=0. 7-5 → 2, out_cout=1. 0x8000_0000-1 → 0x7FFF_FFFF with out_ovf=1.
- Back-pressure:
  - Stream 10 random beats with out_ready toggling 1,0,0,1…
  - Required: every result matches the reference model, order is kept, and out_* are stable during stalls.
  - in_ready=0 whenever the pipe is full and out_ready=0.
- Assert rst for one cycle with 3 beats in flight → no out_valid pulse; the next beat is accepted the cycle after reset and emerges with normal latency.
- WIDTH=64, SEG_WIDTH=16, back-to-back beats → one result per cycle after a 4-cycle fill.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, stage-count helper and per-stage control struct for cla_pipe_adder
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_nseg(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
    logic p_acc;
    logic g_acc;
  } cla_stage_ctrl_t;

endpackage

// File: rtl/cla_segment.sv
// rtl/cla_segment.sv - combinational SEG_WIDTH-bit adder: 4-bit lookahead groups plus a second lookahead level
module cla_segment
  import cla_pkg::*;
#(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 p,
  output logic                 g
);

  localparam int NGRP = SEG_WIDTH / CLA_GROUP;

  logic [SEG_WIDTH-1:0] bit_p;
  logic [SEG_WIDTH-1:0] bit_g;
  logic [SEG_WIDTH-1:0] bit_c;
  logic [NGRP-1:0]      grp_p;
  logic [NGRP-1:0]      grp_g;
  logic [NGRP:0]        grp_c;
  logic                 t_grp;
  logic                 t_lvl2;
  logic                 t_bit;

  assign bit_p = a ^ b;
  assign bit_g = a & b;

  // Every carry is a flat sum of products: each generate term ANDed with all propagates above it.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    t_grp = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      grp_p[j] = &bit_p[j*CLA_GROUP +: CLA_GROUP];
      for (int i = 0; i < CLA_GROUP; i++) begin
        t_grp = bit_g[j*CLA_GROUP + i];
        for (int m = i + 1; m < CLA_GROUP; m++) t_grp = t_grp & bit_p[j*CLA_GROUP + m];
        grp_g[j] = grp_g[j] | t_grp;
      end
    end
  end

  always_comb begin
    grp_c  = '0;
    g      = 1'b0;
    t_lvl2 = 1'b0;
    for (int j = 0; j <= NGRP; j++) begin
      t_lvl2 = cin;
      for (int m = 0; m < j; m++) t_lvl2 = t_lvl2 & grp_p[m];
      grp_c[j] = t_lvl2;
      for (int i = 0; i < j; i++) begin
        t_lvl2 = grp_g[i];
        for (int m = i + 1; m < j; m++) t_lvl2 = t_lvl2 & grp_p[m];
        grp_c[j] = grp_c[j] | t_lvl2;
      end
    end
    for (int i = 0; i < NGRP; i++) begin
      t_lvl2 = grp_g[i];
      for (int m = i + 1; m < NGRP; m++) t_lvl2 = t_lvl2 & grp_p[m];
      g = g | t_lvl2;
    end
  end

  always_comb begin
    bit_c = '0;
    t_bit = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      for (int k = 0; k < CLA_GROUP; k++) begin
        t_bit = grp_c[j];
        for (int m = 0; m < k; m++) t_bit = t_bit & bit_p[j*CLA_GROUP + m];
        bit_c[j*CLA_GROUP + k] = t_bit;
        for (int i = 0; i < k; i++) begin
          t_bit = bit_g[j*CLA_GROUP + i];
          for (int m = i + 1; m < k; m++) t_bit = t_bit & bit_p[j*CLA_GROUP + m];
          bit_c[j*CLA_GROUP + k] = bit_c[j*CLA_GROUP + k] | t_bit;
        end
      end
    end
  end

  assign sum  = bit_p ^ bit_c;
  assign cout = grp_c[NGRP];
  assign p    = &grp_p;

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined segmented CLA adder/subtractor with valid/ready handshake
// Define CLA_FLAGS_EN to add the registered out_zero / out_ovf flags.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_p,
`ifdef CLA_FLAGS_EN
  output logic             out_g,
  output logic             out_zero,
  output logic             out_ovf
`else
  output logic             out_g
`endif
);

  localparam int NSEG = cla_nseg(WIDTH, SEG_WIDTH);

  // a/b keep the not-yet-resolved segments; sum fills in one segment per stage.
  typedef struct packed {
    cla_stage_ctrl_t  ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t               stage_q [NSEG];
  stage_t               stage_d [NSEG];
  logic [SEG_WIDTH-1:0] seg_a   [NSEG];
  logic [SEG_WIDTH-1:0] seg_b   [NSEG];
  logic [SEG_WIDTH-1:0] seg_sum [NSEG];
  logic [NSEG-1:0]      seg_cin;
  logic [NSEG-1:0]      seg_cout;
  logic [NSEG-1:0]      seg_p;
  logic [NSEG-1:0]      seg_g;
  logic [WIDTH-1:0]     b_eff;
  logic                 c0;
  logic                 advance;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign b_eff    = in_sub ? ~in_b : in_b;
  assign c0       = in_sub | in_cin;

  always_comb begin
    seg_cin    = '0;
    seg_a[0]   = in_a[SEG_WIDTH-1:0];
    seg_b[0]   = b_eff[SEG_WIDTH-1:0];
    seg_cin[0] = c0;
    for (int k = 1; k < NSEG; k++) begin
      seg_a[k]   = stage_q[k-1].a[k*SEG_WIDTH +: SEG_WIDTH];
      seg_b[k]   = stage_q[k-1].b[k*SEG_WIDTH +: SEG_WIDTH];
      seg_cin[k] = stage_q[k-1].ctrl.carry;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    cla_segment #(
      .SEG_WIDTH(SEG_WIDTH)
    ) u_seg (
      .a   (seg_a[k]),
      .b   (seg_b[k]),
      .cin (seg_cin[k]),
      .sum (seg_sum[k]),
      .cout(seg_cout[k]),
      .p   (seg_p[k]),
      .g   (seg_g[k])
    );
  end

  always_comb begin
    stage_d[0].ctrl.valid = in_valid;
    stage_d[0].ctrl.carry = seg_cout[0];
    stage_d[0].ctrl.p_acc = seg_p[0];
    stage_d[0].ctrl.g_acc = seg_g[0];
    stage_d[0].a          = in_a;
    stage_d[0].b          = b_eff;
    stage_d[0].sum        = '0;
    stage_d[0].sum[SEG_WIDTH-1:0] = seg_sum[0];
    for (int k = 1; k < NSEG; k++) begin
      stage_d[k]            = stage_q[k-1];
      stage_d[k].ctrl.carry = seg_cout[k];
      stage_d[k].ctrl.p_acc = stage_q[k-1].ctrl.p_acc & seg_p[k];
      stage_d[k].ctrl.g_acc = seg_g[k] | (seg_p[k] & stage_q[k-1].ctrl.g_acc);
      stage_d[k].sum[k*SEG_WIDTH +: SEG_WIDTH] = seg_sum[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) stage_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < NSEG; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out_valid = stage_q[NSEG-1].ctrl.valid;
  assign out_sum   = stage_q[NSEG-1].sum;
  assign out_cout  = stage_q[NSEG-1].ctrl.carry;
  assign out_p     = stage_q[NSEG-1].ctrl.p_acc;
  assign out_g     = stage_q[NSEG-1].ctrl.g_acc;

`ifdef CLA_FLAGS_EN
  logic zero_q;
  logic ovf_q;
  logic ovf_d;

  // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
  assign ovf_d = seg_sum[NSEG-1][SEG_WIDTH-1] ^ seg_a[NSEG-1][SEG_WIDTH-1]
               ^ seg_b[NSEG-1][SEG_WIDTH-1] ^ seg_cout[NSEG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      zero_q <= (stage_d[NSEG-1].sum == '0);
      ovf_q  <= ovf_d;
    end
  end

  assign out_zero = zero_q;
  assign out_ovf  = ovf_q;
`endif

endmodule
